// File: rtl/systolic_sequencer.sv
// systolic_sequencer: job controller around a bit-level systolic array.
// Loads 2N interleaved operand words (A0,B0,A1,B1,...) over a valid/ready stream,
// replays them to the array as in1/in2 pairs, flushes with N zero cycles, runs an
// N+1 cycle readout capturing N result words, then drains them over a second
// valid/ready stream.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid/in_ready   operand input stream (ready only in LOAD)
//   usexor_in             accumulate mode, sampled with the first word of a job
//   sa_in1/sa_in2/sa_valid/sa_readout/sa_usexor  array drive
//   sa_out                array result word (valid while sa_readout)
//   res_data/res_valid/res_ready  result output stream
//   busy                  high unless idle in LOAD with nothing loaded
// Option: SYSTOLIC_SEQ_CHECKSUM_EN appends an XOR-of-results word to the drain.
module systolic_sequencer #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         usexor_in,
   output logic [N-1:0] sa_in1,
   output logic [N-1:0] sa_in2,
   output logic         sa_valid,
   output logic         sa_readout,
   output logic         sa_usexor,
   input  logic [N-1:0] sa_out,
   output logic [N-1:0] res_data,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         busy
);
   localparam int CW = $clog2(2*N+1);
   localparam int IW = $clog2(N);
`ifdef SYSTOLIC_SEQ_CHECKSUM_EN
   localparam int LAST = N;
`else
   localparam int LAST = N-1;
`endif
   typedef enum logic [2:0] {LOAD, FEED, FLUSH, READOUT, DRAIN} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mode_q, mode_d;
   logic [N-1:0]  opa_q [N];
   logic [N-1:0]  opa_d [N];
   logic [N-1:0]  opb_q [N];
   logic [N-1:0]  opb_d [N];
   logic [N-1:0]  res_q [N];
   logic [N-1:0]  res_d [N];
   logic [IW-1:0] load_slot, cur, prev;
   // one counter serves as load beat count, phase cycle count and drain index
   assign load_slot = IW'(cnt_q >> 1);
   assign cur       = IW'(cnt_q);
   assign prev      = IW'(cnt_q - 1'b1);
   assign in_ready   = state_q == LOAD;
   assign busy       = !(state_q == LOAD && cnt_q == '0);
   assign sa_in1     = state_q == FEED ? opa_q[cur] : '0;
   assign sa_in2     = state_q == FEED ? opb_q[cur] : '0;
   assign sa_valid   = state_q == FEED || state_q == FLUSH;
   assign sa_readout = state_q == READOUT;
   assign sa_usexor  = mode_q;
   assign res_valid  = state_q == DRAIN;
`ifdef SYSTOLIC_SEQ_CHECKSUM_EN
   logic [N-1:0] chk_q, chk_d;
   assign res_data = state_q != DRAIN ? '0 : cnt_q == CW'(N) ? chk_q : res_q[cur];
   // first readout cycle clears the running XOR, later cycles fold in each result
   always_comb chk_d = state_q != READOUT ? chk_q : cnt_q == '0 ? '0 : chk_q ^ sa_out;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) chk_q <= '0;
      else chk_q <= chk_d;
`else
   assign res_data = state_q == DRAIN ? res_q[cur] : '0;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      case (state_q)
         LOAD: if (in_valid) begin
            if (cnt_q[0]) opb_d[load_slot] = in_data;
            else opa_d[load_slot] = in_data;
            if (cnt_q == '0) mode_d = usexor_in;
            cnt_d   = cnt_q == CW'(2*N-1) ? '0 : cnt_q + 1'b1;
            state_d = cnt_q == CW'(2*N-1) ? FEED : LOAD;
         end
         FEED, FLUSH: begin
            cnt_d   = cnt_q == CW'(N-1) ? '0 : cnt_q + 1'b1;
            state_d = cnt_q != CW'(N-1) ? state_q : state_q == FEED ? FLUSH : READOUT;
         end
         READOUT: begin
            // the first readout cycle carries no result; cycles 1..N fill R0..R(N-1)
            if (cnt_q != '0) res_d[prev] = sa_out;
            cnt_d   = cnt_q == CW'(N) ? '0 : cnt_q + 1'b1;
            state_d = cnt_q == CW'(N) ? DRAIN : READOUT;
         end
         DRAIN: if (res_ready) begin
            cnt_d   = cnt_q == CW'(LAST) ? '0 : cnt_q + 1'b1;
            state_d = cnt_q == CW'(LAST) ? LOAD : DRAIN;
         end
         default: begin
            state_d = LOAD;
            cnt_d   = '0;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         opa_q   <= '{default: '0};
         opb_q   <= '{default: '0};
         res_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
      end
endmodule
